// File: rtl/jzjpcc_writeback_pkg.sv
// Shared types and helpers for the writeback aligner and its load extractor.
package jzjpcc_writeback_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_BEAT0 = 2'b01,
    WAIT_BEAT1 = 2'b10
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // 3'b111 never exists; ld and lwu only exist on a 64-bit datapath.
  function automatic logic isLegalFunct3(input logic [2:0] funct3, input int xlen);
    if (funct3 == 3'b111) return 1'b0;
    if ((xlen == 32) && ((funct3 == LD) || (funct3 == LWU))) return 1'b0;
    return 1'b1;
  endfunction

  // Number of bytes moved by a load of the given size.
  function automatic logic [3:0] size_bytes(input size_t size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/jzjpcc_writeback_aligner_if.sv
// Memory-stage to writeback-stage bus: operation handshake plus raw data beats.
//
// Handshake: an operation transfers on a rising clock edge where in_valid and
// in_ready are both high; the master keeps every in_* field stable while
// in_valid is high and in_ready is low. The beat channel has no ready: a beat
// (mem_valid high) is consumed only while the slave is waiting for load data
// and is ignored at any other time.
interface jzjpcc_writeback_aligner_if #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic                     in_valid;
  logic                     in_ready;
  logic [RF_ADDR_WIDTH-1:0] in_rdAddr;
  logic                     in_rdWriteEnable;
  logic                     in_rdSource;
  logic [XLEN-1:0]          in_aluResult;
  logic [2:0]               in_funct3;
  logic [OFFW-1:0]          in_byteOffset;
  logic                     mem_valid;
  logic [XLEN-1:0]          mem_data;

  modport master (
    output in_valid, in_rdAddr, in_rdWriteEnable, in_rdSource, in_aluResult,
           in_funct3, in_byteOffset, mem_valid, mem_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rdAddr, in_rdWriteEnable, in_rdSource, in_aluResult,
           in_funct3, in_byteOffset, mem_valid, mem_data,
    output in_ready
  );
endinterface

// File: rtl/jzjpcc_load_extract.sv
// Combinational byte extractor: shifts {beat1, beat0} down by the byte offset,
// keeps the loaded size and sign- or zero-extends it to XLEN.
module jzjpcc_load_extract
  import jzjpcc_writeback_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          beats_i,
  input  logic [$clog2(XLEN/8)-1:0]  byte_offset_i,
  input  size_t                      size_i,
  input  logic                       unsigned_i,
  output logic [XLEN-1:0]            result_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  // Align, mask to the loaded size, then fill the upper bits with the sign or zero.
  always_comb begin
    shifted = XLEN'(beats_i >> {byte_offset_i, 3'b000});
    mask    = '0;
    sign    = 1'b0;
    case (size_i)
      SIZE_B: begin mask = XLEN'(8'hFF);         sign = shifted[7];      end
      SIZE_H: begin mask = XLEN'(16'hFFFF);      sign = shifted[15];     end
      SIZE_W: begin mask = XLEN'(32'hFFFF_FFFF); sign = shifted[31];     end
      SIZE_D: begin mask = '1;                   sign = shifted[XLEN-1]; end
    endcase
    result_o = shifted & mask;
    if (!unsigned_i && sign) result_o = result_o | ~mask;
  end

endmodule

// File: rtl/jzjpcc_writeback_aligner.sv
// Writeback stage: accepts ALU results and loads from the memory stage,
// gathers one or two data beats per load, aligns/extends them and drives a
// registered register-file write port.
module jzjpcc_writeback_aligner
  import jzjpcc_writeback_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int RF_ADDR_WIDTH    = 5,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  jzjpcc_writeback_aligner_if.slave    bus,
  output logic [RF_ADDR_WIDTH-1:0]     rdAddr_writebackEnd,
  output logic [XLEN-1:0]              rd_writebackEnd,
  output logic                         rdWriteEnable_writebackEnd,
  output logic                         loadFault,
  output logic                         busy,
  output state_t                       dbg_state
);

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int SUMW = OFFW + 2;

  state_t                   state_q, state_d;
  logic [XLEN-1:0]          beat0_q, beat0_d;
  logic [RF_ADDR_WIDTH-1:0] op_rd_addr_q, op_rd_addr_d;
  logic                     op_we_q, op_we_d;
  logic [2:0]               op_funct3_q, op_funct3_d;
  logic [OFFW-1:0]          op_offset_q, op_offset_d;
  logic [RF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]          rd_data_q, rd_data_d;
  logic                     rd_we_q, rd_we_d;
  logic                     fault_q, fault_d;

  logic                     accept;
  logic [2*XLEN-1:0]        beats;
  logic [XLEN-1:0]          load_value;
  logic [SUMW-1:0]          span_sum;
  logic                     spans;
  size_t                    op_size;

  assign bus.in_ready = (state_q == IDLE) & ~reset;
  assign busy         = ~bus.in_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign dbg_state    = state_q;

  assign rdAddr_writebackEnd        = rd_addr_q;
  assign rd_writebackEnd            = rd_data_q;
  assign rdWriteEnable_writebackEnd = rd_we_q;
  assign loadFault                  = fault_q;

  assign op_size  = size_t'(op_funct3_q[1:0]);
  assign span_sum = SUMW'(op_offset_q) + SUMW'(size_bytes(op_size));
  assign spans    = span_sum > SUMW'(XLEN / 8);

  // Second beat supplies the high bytes; for a single-beat load the upper half is never selected.
  assign beats = (state_q == WAIT_BEAT1) ? {bus.mem_data, beat0_q} : {bus.mem_data, bus.mem_data};

  jzjpcc_load_extract #(.XLEN(XLEN)) u_extract (
    .beats_i       (beats),
    .byte_offset_i (op_offset_q),
    .size_i        (op_size),
    .unsigned_i    (op_funct3_q[2]),
    .result_o      (load_value)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    beat0_d      = beat0_q;
    op_rd_addr_d = op_rd_addr_q;
    op_we_d      = op_we_q;
    op_funct3_d  = op_funct3_q;
    op_offset_d  = op_offset_q;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    rd_we_d      = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_rd_addr_d = bus.in_rdAddr;
          op_we_d      = bus.in_rdWriteEnable;
          op_funct3_d  = bus.in_funct3;
          op_offset_d  = bus.in_byteOffset;
          if (!bus.in_rdSource) begin
            rd_addr_d = bus.in_rdAddr;
            rd_data_d = bus.in_aluResult;
            rd_we_d   = bus.in_rdWriteEnable & (bus.in_rdAddr != '0);
          end else if (!isLegalFunct3(bus.in_funct3, XLEN)) begin
            fault_d = 1'b1;
          end else begin
            state_d = WAIT_BEAT0;
          end
        end
      end
      WAIT_BEAT0: begin
        if (bus.mem_valid) begin
          if (!spans) begin
            rd_addr_d = op_rd_addr_q;
            rd_data_d = load_value;
            rd_we_d   = op_we_q & (op_rd_addr_q != '0);
            state_d   = IDLE;
          end else if (ALLOW_MISALIGNED) begin
            beat0_d = bus.mem_data;
            state_d = WAIT_BEAT1;
          end else begin
            fault_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_BEAT1: begin
        if (bus.mem_valid) begin
          rd_addr_d = op_rd_addr_q;
          rd_data_d = load_value;
          rd_we_d   = op_we_q & (op_rd_addr_q != '0);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operation register and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      beat0_q      <= '0;
      op_rd_addr_q <= '0;
      op_we_q      <= 1'b0;
      op_funct3_q  <= '0;
      op_offset_q  <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      rd_we_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat0_q      <= beat0_d;
      op_rd_addr_q <= op_rd_addr_d;
      op_we_q      <= op_we_d;
      op_funct3_q  <= op_funct3_d;
      op_offset_q  <= op_offset_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      rd_we_q      <= rd_we_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: doc/jzjpcc_writeback_aligner.md
Name: jzjpcc_writeback_aligner

Overview:
- Parametrised writeback stage. Takes results from the memory stage through a valid/ready handshake.
- Collects one or two raw memory data beats per load and aligns them, including misaligned loads that span two words.
- Applies sign or zero extension and drives a registered write port into the register file.
- Adds stall backpressure, XLEN=64 support (ld/lwu), misaligned-load splitting, x0 write suppression and a fault output.

Parameters:
- XLEN, 32, datapath width in bits. Legal values are 32 and 64.
- RF_ADDR_WIDTH, 5, register-file address width.
- ALLOW_MISALIGNED, 1. When 1, a load spanning a word boundary is split into two beats. When 0, such a load raises loadFault and performs no write.

Ports:
- clock  in  1  Single clock. All state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  Memory stage presents an operation.
- in_ready  out  1  Stage can accept an operation. Equals (state==IDLE) & ~reset.
- in_rdAddr  in  RF_ADDR_WIDTH  Destination register.
- in_rdWriteEnable  in  1  Instruction writes rd.
- in_rdSource  in  1  0 = ALU result, 1 = load data.
- in_aluResult  in  XLEN  ALU result.
- in_funct3  in  3  Load type: bits [1:0] give size (00 byte, 01 half, 10 word, 11 double); bit 2 selects unsigned.
- in_byteOffset  in  $clog2(XLEN/8)  Load address low bits.
- mem_valid  in  1  Data beat present. Sampled only in WAIT_BEAT0 and WAIT_BEAT1.
- mem_data  in  XLEN  Raw beat. Byte lane i = bits [8i+7:8i] holds the byte at word offset i.
- rdAddr_writebackEnd  out  RF_ADDR_WIDTH  Registered write address.
- rd_writebackEnd  out  XLEN  Registered write data.
- rdWriteEnable_writebackEnd  out  1  Registered write strobe; one pulse per write.
- loadFault  out  1  One-cycle pulse for an illegal funct3, or for a misaligned load when ALLOW_MISALIGNED=0.
- busy  out  1  Equals ~in_ready. Used by the hazard unit for stalls and forwarding.

Behaviour:
- Reset:
  - State becomes IDLE.
  - All registered outputs clear: rdAddr_writebackEnd=0, rd_writebackEnd=0, rdWriteEnable_writebackEnd=0, loadFault=0.
  - The beat0 holding register clears.
  - in_ready=0 while reset is high.
  - Reset asserted mid-load abandons the load: no write occurs, and later mem_valid beats are ignored until a new load is accepted.
- Accept condition: an operation is accepted when in_valid & in_ready. All in_* fields are captured into an operation register on acceptance.
- ALU operation (rdSource=0):
  - The write appears on the outputs the cycle after acceptance (latency 1).
  - State stays IDLE, so back-to-back ALU operations sustain one per cycle.
- Load, IDLE -> WAIT_BEAT0:
  - Taken on acceptance.
  - If funct3 is illegal, there is instead a loadFault pulse the next cycle, no write, and state stays IDLE.
  - Illegal funct3 values: 3'b011 or 3'b110 when XLEN=32; 3'b111 always.
- WAIT_BEAT0, on mem_valid:
  - Spanning test: byteOffset + size_bytes > XLEN/8 means the load spans two words.
  - Not spanning: extract, extend and write the next cycle, then go to IDLE.
  - Spanning with ALLOW_MISALIGNED=1: store beat0 and go to WAIT_BEAT1.
  - Spanning with ALLOW_MISALIGNED=0: loadFault pulse the next cycle, no write, go to IDLE.
- WAIT_BEAT1, on mem_valid:
  - Low bytes come from beat0 lanes [byteOffset .. XLEN/8-1].
  - The remaining high bytes come from beat1 lanes [0 .. ].
  - Bytes assemble little-endian, then extend. Write the next cycle, then go to IDLE.
- mem_valid low in a WAIT state: hold the state indefinitely. There is no timeout.
- Write suppression: rdWriteEnable_writebackEnd is 0 whenever in_rdWriteEnable=0 or rdAddr==0. The load sequence still consumes its beats in that case.
- Output timing:
  - rdWriteEnable_writebackEnd and loadFault are deasserted in every cycle that does not complete an operation.
  - rdAddr_writebackEnd and rd_writebackEnd hold their last value.
- Extension:
  - Signed loads replicate the MSB of the loaded size up to XLEN.
  - Unsigned loads zero-fill.
  - A word load with XLEN=32 passes through unchanged.
- Simultaneity:
  - A write completing in cycle N does not block acceptance in cycle N, because the state is already IDLE.
  - A new load accepted in the cycle after a write completes behaves normally.

Decomposition:
- Package jzjpcc_writeback_pkg:
  - size enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D).
  - state enum (IDLE, WAIT_BEAT0, WAIT_BEAT1).
  - funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU).
  - function isLegalFunct3(funct3, XLEN).
- Sub-module jzjpcc_load_extract (combinational):
  - Inputs: {beat1, beat0} concatenated, byteOffset, size, unsigned flag.
  - Output: the extended XLEN result.
  - Reused by the future store path.

Test Plan (XLEN=32):
- ALU stream: three back-to-back ALU ops (rd=1/2/3, aluResult=0x11/0x22/0x33), in_valid held -> writes on three consecutive cycles, in_ready=1 throughout.
- Aligned lb: offset=2, mem_data=0x80FF0000 -> rd=0xFFFFFFFF. Same load as lbu -> 0x000000FF. Same load as lw at offset=0 with mem_data=0x12345678 -> 0x12345678.
- Misaligned lh: offset=3, beat0=0xAABBCCDD, beat1=0x11223344 -> rd=0x000044AA; busy=1 from acceptance until the beat1 cycle.
- ALLOW_MISALIGNED=0, lw at offset=1 -> loadFault pulses for exactly 1 cycle, no write, state returns to IDLE.
- rd=0 load, plus a load with in_rdWriteEnable=0 -> beats consumed, rdWriteEnable_writebackEnd stays 0.
- Reset asserted in WAIT_BEAT1 -> all outputs clear, a stale mem_valid beat is ignored, and the next ALU op writes correctly.
